// File: rtl/dram_rmw.sv
// Single-port data RAM with native read-modify-write add and a hardware
// clear sequencer that zeroes the whole array after reset or on request.
//
// state  | meaning
// -------+----------------------------------------------------------
// CLEAR  | zeroing sweep, one cell per cycle; READY=0
// IDLE   | accepting read / write / add commands; READY=1
// ADD_WR | write-back half of an add (old + delta); READY=0
module dram_rmw #(
   parameter int DA_WIDTH = 11,
   parameter int DD_WIDTH = 8,
   parameter int DA_DEPTH = 1 << DA_WIDTH
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [DA_WIDTH-1:0] A,
   input  logic [DD_WIDTH-1:0] DIN,
   input  logic [DD_WIDTH-1:0] DELTA,
   input  logic                EN,
   input  logic                WE,
   input  logic                ADD,
   input  logic                CLR,
   output logic [DD_WIDTH-1:0] DOUT,
   output logic                VALID,
   output logic                READY
);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_IDLE   = 2'd1,
      S_ADD_WR = 2'd2
   } state_t;

   localparam logic [DA_WIDTH-1:0] LAST_ADDR = DA_WIDTH'(DA_DEPTH - 1);

   logic [DD_WIDTH-1:0] mem [DA_DEPTH];

   state_t              state;
   logic [DA_WIDTH-1:0] cnt;
   logic [DA_WIDTH-1:0] a_lat;
   logic [DD_WIDTH-1:0] delta_lat;
   logic [DD_WIDTH-1:0] old_q;
   logic [DD_WIDTH-1:0] dout_r;
   logic                valid_r;
   logic                ready_r;

   logic                cmd_go;
   logic                mem_we;
   logic [DA_WIDTH-1:0] mem_addr;
   logic [DD_WIDTH-1:0] mem_wdata;
   logic                dout_load;
   logic                add_load;
   logic [DD_WIDTH-1:0] sum;

   // carry out of the add is deliberately dropped: cells wrap modulo 2^DD_WIDTH
   assign sum    = old_q + delta_lat;
   assign cmd_go = (state == S_IDLE) && !CLR && EN;

   // single-port address/write steering; nothing touches the array while RST=1
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = A;
      mem_wdata = DIN;
      dout_load = 1'b0;
      add_load  = 1'b0;
      if (!RST) begin
         case (state)
            S_CLEAR: begin
               mem_we    = 1'b1;
               mem_addr  = cnt;
               mem_wdata = '0;
            end
            S_IDLE: begin
               if (cmd_go) begin
                  if (WE) begin
                     mem_we    = 1'b1;
                     dout_load = 1'b1;
                  end else if (ADD) begin
                     add_load  = 1'b1;
                  end else begin
                     dout_load = 1'b1;
                  end
               end
            end
            S_ADD_WR: begin
               mem_we    = 1'b1;
               mem_addr  = a_lat;
               mem_wdata = sum;
               dout_load = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // array write port, kept reset-free so it maps onto block RAM
   always_ff @(posedge CLK) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   // read side of the port: write-first data out, plus the add operand capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         dout_r <= '0;
         old_q  <= '0;
      end else begin
         if (dout_load)
            dout_r <= mem_we ? mem_wdata : mem[mem_addr];
         if (add_load)
            old_q <= mem[mem_addr];
      end
   end

   // sequencer: sweep, command decode and add write-back
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_CLEAR;
         cnt       <= '0;
         a_lat     <= '0;
         delta_lat <= '0;
         valid_r   <= 1'b0;
         ready_r   <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            S_CLEAR: begin
               if (cnt == LAST_ADDR) begin
                  state   <= S_IDLE;
                  cnt     <= '0;
                  ready_r <= 1'b1;
               end else begin
                  cnt <= cnt + DA_WIDTH'(1);
               end
            end
            S_IDLE: begin
               if (CLR) begin
                  state   <= S_CLEAR;
                  cnt     <= '0;
                  ready_r <= 1'b0;
               end else if (EN) begin
                  if (!WE && ADD) begin
                     a_lat     <= A;
                     delta_lat <= DELTA;
                     state     <= S_ADD_WR;
                     ready_r   <= 1'b0;
                  end else begin
                     valid_r <= 1'b1;
                  end
               end
            end
            S_ADD_WR: begin
               valid_r <= 1'b1;
               state   <= S_IDLE;
               ready_r <= 1'b1;
            end
            default: begin
               state   <= S_CLEAR;
               cnt     <= '0;
               ready_r <= 1'b0;
            end
         endcase
      end
   end

   assign DOUT  = dout_r;
   assign VALID = valid_r;
   assign READY = ready_r;

endmodule

// File: tb/tb_dram_rmw.sv
// Directed bench for dram_rmw at DA_WIDTH=4 (16 cells), 8-bit data.
module tb_dram_rmw;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [AW-1:0] A;
   logic [DW-1:0] DIN;
   logic [DW-1:0] DELTA;
   logic          EN;
   logic          WE;
   logic          ADD;
   logic          CLR;
   logic [DW-1:0] DOUT;
   logic          VALID;
   logic          READY;

   int n_assert = 0;
   int n_fail   = 0;

   dram_rmw #(.DA_WIDTH(AW), .DD_WIDTH(DW)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .A     (A),
      .DIN   (DIN),
      .DELTA (DELTA),
      .EN    (EN),
      .WE    (WE),
      .ADD   (ADD),
      .CLR   (CLR),
      .DOUT  (DOUT),
      .VALID (VALID),
      .READY (READY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle just past it
   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      EN = 1'b0; WE = 1'b0; ADD = 1'b0; CLR = 1'b0;
   endtask

   // count edges until READY, watching VALID and DOUT stay quiet
   task automatic wait_ready(input logic [DW-1:0] hold, output int n,
                             output logic vbad, output logic dbad);
      n = 0; vbad = 1'b0; dbad = 1'b0;
      for (int i = 0; i < 64; i++) begin
         cycle();
         n++;
         if (VALID) vbad = 1'b1;
         if (DOUT !== hold) dbad = 1'b1;
         if (READY) break;
      end
   endtask

   task automatic write_cell(input logic [AW-1:0] a, input logic [DW-1:0] d);
      EN = 1'b1; WE = 1'b1; ADD = 1'b0; A = a; DIN = d;
      cycle();
      idle_inputs();
   endtask

   task automatic read_cell(input logic [AW-1:0] a);
      EN = 1'b1; WE = 1'b0; ADD = 1'b0; A = a;
      cycle();
      idle_inputs();
   endtask

   task automatic all_zero(input string tag);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         EN = 1'b1; WE = 1'b0; ADD = 1'b0; A = AW'(i);
         cycle();
         if (DOUT !== 8'h00 || VALID !== 1'b1) bad = 1'b1;
      end
      idle_inputs();
      check(tag, {31'd0, bad}, 32'd0);
   endtask

   initial begin
      int   n;
      logic vbad, dbad;

      RST = 1'b1; A = '0; DIN = '0; DELTA = '0;
      idle_inputs();

      // reset state, then garbage preload and a 3-cycle reset pulse
      cycle();
      cycle();
      check("rst_ready", {31'd0, READY}, 32'd0);
      check("rst_valid", {31'd0, VALID}, 32'd0);
      check("rst_dout",  {24'd0, DOUT},  32'h00);
      for (int i = 0; i < 16; i++) dut.mem[i] = 8'hA0 + 8'(i);
      cycle();
      RST = 1'b0;
      wait_ready(8'h00, n, vbad, dbad);
      check("sweep_len",   n, 16);
      check("sweep_valid", {31'd0, vbad}, 32'd0);
      all_zero("sweep_zero");

      // write then read back-to-back
      EN = 1'b1; WE = 1'b1; A = 4'd3; DIN = 8'h5A;
      cycle();
      check("wr_dout",  {24'd0, DOUT}, 32'h5A);
      check("wr_valid", {31'd0, VALID}, 32'd1);
      WE = 1'b0;
      cycle();
      idle_inputs();
      check("rd_dout",  {24'd0, DOUT}, 32'h5A);
      check("rd_valid", {31'd0, VALID}, 32'd1);
      cycle();
      check("idle_valid", {31'd0, VALID}, 32'd0);
      check("idle_hold",  {24'd0, DOUT}, 32'h5A);

      // add wrap: 0xFF + 1 = 0x00, then 0x00 + 0xFF = 0xFF
      write_cell(4'd7, 8'hFF);
      EN = 1'b1; ADD = 1'b1; A = 4'd7; DELTA = 8'h01;
      cycle();
      idle_inputs();
      check("add1_ready", {31'd0, READY}, 32'd0);
      check("add1_novld", {31'd0, VALID}, 32'd0);
      cycle();
      check("add1_dout",  {24'd0, DOUT}, 32'h00);
      check("add1_valid", {31'd0, VALID}, 32'd1);
      check("add1_rdy",   {31'd0, READY}, 32'd1);
      EN = 1'b1; ADD = 1'b1; A = 4'd7; DELTA = 8'hFF;
      cycle();
      idle_inputs();
      cycle();
      check("add2_dout", {24'd0, DOUT}, 32'hFF);
      read_cell(4'd7);
      check("add2_rd", {24'd0, DOUT}, 32'hFF);

      // WE beats ADD: plain write, no write-back cycle
      EN = 1'b1; WE = 1'b1; ADD = 1'b1; A = 4'd5; DIN = 8'h11; DELTA = 8'h40;
      cycle();
      idle_inputs();
      check("pri_dout",  {24'd0, DOUT}, 32'h11);
      check("pri_ready", {31'd0, READY}, 32'd1);
      read_cell(4'd5);
      check("pri_rd", {24'd0, DOUT}, 32'h11);

      // EN held during ADD_WR is dropped
      EN = 1'b1; ADD = 1'b1; A = 4'd5; DELTA = 8'h02;
      cycle();
      WE = 1'b1; ADD = 1'b0; A = 4'd6; DIN = 8'h77;
      cycle();
      idle_inputs();
      check("drop_sum", {24'd0, DOUT}, 32'h13);
      cycle();
      read_cell(4'd6);
      check("drop_cell6", {24'd0, DOUT}, 32'h00);
      read_cell(4'd5);
      check("drop_cell5", {24'd0, DOUT}, 32'h13);

      // reset during ADD_WR: no write-back, sweep restarts
      EN = 1'b1; ADD = 1'b1; A = 4'd5; DELTA = 8'h01;
      cycle();
      idle_inputs();
      RST = 1'b1;
      cycle();
      check("radd_mem",   {24'd0, dut.mem[5]}, 32'h13);
      check("radd_ready", {31'd0, READY}, 32'd0);
      check("radd_dout",  {24'd0, DOUT}, 32'h00);
      RST = 1'b0;
      wait_ready(8'h00, n, vbad, dbad);
      check("radd_sweep", n, 16);
      read_cell(4'd5);
      check("radd_cell5", {24'd0, DOUT}, 32'h00);

      // reset when the sweep has reached address 9
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      for (int i = 0; i < 9; i++) cycle();
      check("rsw_busy", {31'd0, READY}, 32'd0);
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      wait_ready(8'h00, n, vbad, dbad);
      check("rsw_len", n, 16);

      // runtime clear; CLR arrives together with a write and wins
      for (int i = 0; i < 16; i++) write_cell(AW'(i), 8'(i * 3 + 1));
      check("fill_last", {24'd0, DOUT}, 32'h2E);
      EN = 1'b1; WE = 1'b1; CLR = 1'b1; A = 4'd2; DIN = 8'h99;
      cycle();
      idle_inputs();
      check("clr_ready", {31'd0, READY}, 32'd0);
      check("clr_dout0", {24'd0, DOUT}, 32'h2E);
      wait_ready(8'h2E, n, vbad, dbad);
      check("clr_len",   n, 16);
      check("clr_valid", {31'd0, vbad}, 32'd0);
      check("clr_hold",  {31'd0, dbad}, 32'd0);
      all_zero("clr_zero");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
